// File: rtl/lm70_pkg.sv
// lm70_pkg: shared constants, state encoding and helpers for the LM70 SPI responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lm70_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int          TEMP_W     = 11;
  localparam logic [4:0]  TAIL       = 5'b11100;
  localparam logic [5:0]  READ_BITS  = 6'd16;
  localparam logic [5:0]  FRAME_BITS = 6'd32;

  localparam logic [15:0] ID_CODE_DEF  = 16'h8100;
  localparam logic [7:0]  CMD_SHDN_DEF = 8'hFF;
  localparam logic [7:0]  CMD_WAKE_DEF = 8'h00;

  // Word served on a read: temperature plus fixed tail, or the ID in shutdown.
  function automatic logic [15:0] frame_word(input logic            shdn,
                                             input logic [TEMP_W-1:0] temp,
                                             input logic [15:0]     id);
    return shdn ? id : {temp, TAIL};
  endfunction

  // Bit counter never wraps: it holds at FRAME_BITS.
  function automatic logic [5:0] cnt_inc(input logic [5:0] c);
    return (c >= FRAME_BITS) ? FRAME_BITS : c + 6'd1;
  endfunction

endpackage

// File: rtl/lm70_spi_responder_sync_edge_det.sv
// sync_edge_det: N-stage synchroniser for one async pin with registered-copy rise/fall pulses.
// Latency: level valid N clks after the pin; rise/fall pulse visible N clks after the pin.
// Backpressure: none; free-running sampler.
// Ports: clk/rst (sync active-high), d_i async pin, q_o synchronised level,
//        rise_o/fall_o one-clk edge pulses.
module sync_edge_det #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {N{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
    end
  end

  assign q_o    = sync_q[N-1];
  assign rise_o = sync_q[N-1] & ~prev_q;
  assign fall_o = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/lm70_spi_responder.sv
// lm70_spi_responder: LM70 sensor side of the 3-wire SPI link (16-bit read, 16-bit command write).
// Latency: pin edge to state/output change is SYNC_STAGES+1 clks.
// Backpressure: none; follows the master's CS/SCK, frame_done/cmd_valid are one-clk pulses.
// Ports: clk/rst (sync active-high); temp_in temperature; cs_n/sck/sio_in from master;
//        sio_out/sio_oe pad drive; shutdown mode; frame_done/cmd_valid status pulses.
module lm70_spi_responder
  import lm70_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] ID_CODE     = ID_CODE_DEF,
  parameter logic [7:0]  CMD_SHDN    = CMD_SHDN_DEF,
  parameter logic [7:0]  CMD_WAKE    = CMD_WAKE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic              cs_n,
  input  logic              sck,
  input  logic              sio_in,
  output logic              sio_out,
  output logic              sio_oe,
  output logic              shutdown,
  output logic              frame_done,
  output logic              cmd_valid
);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic sio_lvl, sio_rise_unused, sio_fall_unused;

  sync_edge_det #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d_i(cs_n),
    .q_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));

  sync_edge_det #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .d_i(sck),
    .q_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall));

  sync_edge_det #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sio (
    .clk(clk), .rst(rst), .d_i(sio_in),
    .q_o(sio_lvl), .rise_o(sio_rise_unused), .fall_o(sio_fall_unused));

  state_e      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d, cnt_nxt;
  logic [15:0] shift_q, shift_d;
  logic [15:0] cmd_sr_q, cmd_sr_d;
  logic        oe_q, oe_d;
  logic        shdn_q, shdn_d;
  logic        skip_q, skip_d;
  logic        fd_q, fd_d;
  logic        cv_q, cv_d;
  logic        cs_lvl_unused;
  logic [7:0]  cmd_hi_unused;

  assign cnt_nxt       = cnt_inc(bit_cnt_q);
  assign cs_lvl_unused = cs_lvl;
  assign cmd_hi_unused = cmd_sr_q[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      cmd_sr_q  <= '0;
      oe_q      <= 1'b0;
      shdn_q    <= 1'b0;
      skip_q    <= 1'b0;
      fd_q      <= 1'b0;
      cv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      cmd_sr_q  <= cmd_sr_d;
      oe_q      <= oe_d;
      shdn_q    <= shdn_d;
      skip_q    <= skip_d;
      fd_q      <= fd_d;
      cv_q      <= cv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    cmd_sr_d  = cmd_sr_q;
    oe_d      = oe_q;
    shdn_d    = shdn_q;
    skip_d    = skip_q;
    fd_d      = 1'b0;
    cv_d      = 1'b0;

    // CS rise wins over any SCK edge on the same clk.
    if (cs_rise) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      if ((state_q == ST_WRITE || state_q == ST_DONE) && bit_cnt_q >= READ_BITS)
        fd_d = 1'b1;
      if (state_q == ST_DONE) begin
        cv_d = 1'b1;
        if (cmd_sr_q[7:0] == CMD_SHDN)      shdn_d = 1'b1;
        else if (cmd_sr_q[7:0] == CMD_WAKE) shdn_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          oe_d = 1'b0;
          if (cs_fall) begin
            shift_d   = frame_word(shdn_q, temp_in, ID_CODE);
            oe_d      = 1'b1;
            bit_cnt_d = '0;
            // SCK already high at select: let its falling edge pass unused.
            skip_d    = sck_lvl;
            state_d   = ST_READ;
          end
        end
        ST_READ: begin
          if (sck_fall) begin
            if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              bit_cnt_d = cnt_nxt;
              shift_d   = {shift_q[14:0], 1'b0};
              if (cnt_nxt == READ_BITS) begin
                oe_d    = 1'b0;
                state_d = ST_WRITE;
              end
            end
          end
        end
        ST_WRITE: begin
          if (sck_rise) begin
            cmd_sr_d  = {cmd_sr_q[14:0], sio_lvl};
            bit_cnt_d = cnt_nxt;
            if (cnt_nxt == FRAME_BITS) state_d = ST_DONE;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // sio_out is the MSB of the shift word; it is zero out of reset.
  assign sio_out    = shift_q[15];
  assign sio_oe     = oe_q;
  assign shutdown   = shdn_q;
  assign frame_done = fd_q;
  assign cmd_valid  = cv_q;

endmodule

// File: tb/tb_lm70_spi_responder.sv
`timescale 1ns/1ps
module tb_lm70_spi_responder;

  localparam int HALF = 6;  // SCK half period in clk cycles (SCK = clk/12)

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] temp_in;
  logic        cs_n, sck, sio_in;
  logic        sio_out, sio_oe, shutdown, frame_done, cmd_valid;

  always #5 clk = ~clk;

  lm70_spi_responder dut (
    .clk(clk), .rst(rst), .temp_in(temp_in), .cs_n(cs_n), .sck(sck),
    .sio_in(sio_in), .sio_out(sio_out), .sio_oe(sio_oe), .shutdown(shutdown),
    .frame_done(frame_done), .cmd_valid(cmd_valid));

  typedef struct {bit cmd; bit shdn;} evt_t;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_rd_q[$];
  logic [15:0] obs_rd_q[$];
  evt_t        exp_evt_q[$];

  // Reference model state: just the shutdown mode.
  bit model_shdn = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT presents a read word or a pulse.
  always @(negedge clk) begin
    if (obs_rd_q.size() > 0) begin
      if (exp_rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got %h expected none", obs_rd_q.pop_front());
      end else begin
        chk("rd_word", {16'h0, obs_rd_q.pop_front()}, {16'h0, exp_rd_q.pop_front()});
      end
    end
    if (!rst && (frame_done || cmd_valid)) begin
      if (exp_evt_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL evt_unexpected: got fd=%b cv=%b expected no pulse", frame_done, cmd_valid);
      end else begin
        evt_t e;
        e = exp_evt_q.pop_front();
        chk("frame_done", {31'h0, frame_done}, 32'h1);
        chk("cmd_valid",  {31'h0, cmd_valid},  {31'h0, e.cmd});
        chk("shutdown",   {31'h0, shutdown},   {31'h0, e.shdn});
      end
    end
  end

  // One master frame: n_sck clocks, 16 read bits then wr MSB-first; optional temp change at SCK chg_at.
  task automatic frame(input int n_sck, input logic [15:0] wr,
                       input int chg_at, input logic [10:0] chg_val);
    logic [15:0] rd;
    rd = '0;
    if (n_sck >= 16)
      exp_rd_q.push_back(model_shdn ? 16'h8100 : {temp_in, 3'b111, 2'b00});
    cs_n = 1'b0;
    wait_clk(HALF + 4);
    for (int i = 0; i < n_sck; i++) begin
      if (i >= 16) sio_in = wr[31 - i];
      if (i == chg_at) temp_in = chg_val;
      wait_clk(HALF);
      sck = 1'b1;
      if (i == 0) chk("oe_in_read", {31'h0, sio_oe}, 32'h1);
      if (i < 16) rd = {rd[14:0], sio_out};
      wait_clk(HALF);
      sck = 1'b0;
    end
    wait_clk(HALF);
    if (n_sck >= 16) begin
      if (n_sck == 32) begin
        if (wr[7:0] == 8'hFF)      model_shdn = 1'b1;
        else if (wr[7:0] == 8'h00) model_shdn = 1'b0;
      end
      exp_evt_q.push_back('{cmd: (n_sck == 32), shdn: model_shdn});
    end
    cs_n = 1'b1;
    if (n_sck >= 16) obs_rd_q.push_back(rd);
    wait_clk(12);
    chk("oe_idle", {31'h0, sio_oe}, 32'h0);
    wait_clk(4);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; temp_in = 11'h064; cs_n = 1'b1; sck = 1'b0; sio_in = 1'b0;
    wait_clk(3);
    chk("rst_sio_out",    {31'h0, sio_out},    32'h0);
    chk("rst_sio_oe",     {31'h0, sio_oe},     32'h0);
    chk("rst_shutdown",   {31'h0, shutdown},   32'h0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
    chk("rst_cmd_valid",  {31'h0, cmd_valid},  32'h0);
    rst = 1'b0;
    wait_clk(8);

    // +25.00 C read
    temp_in = 11'h064; frame(16, 16'h0, -1, 11'h0);
    // -25.00 C read, temperature changes mid-frame
    temp_in = 11'h79C; frame(16, 16'h0, 5, 11'h000);
    // enter shutdown, read ID, wake, read temperature
    temp_in = 11'h064;
    frame(32, 16'h00FF, -1, 11'h0);
    frame(16, 16'h0, -1, 11'h0);
    frame(32, 16'h0000, -1, 11'h0);
    frame(16, 16'h0, -1, 11'h0);
    // unrecognised command, then a short write
    frame(32, 16'h0055, -1, 11'h0);
    frame(31, 16'h00FF, -1, 11'h0);
    chk("shdn_after_31", {31'h0, shutdown}, 32'h0);
    // aborted read, then a full read
    frame(7, 16'h0, -1, 11'h0);
    frame(16, 16'h0, -1, 11'h0);

    // reset while in WRITE with shutdown set
    frame(32, 16'h00FF, -1, 11'h0);
    cs_n = 1'b0;
    wait_clk(HALF + 4);
    for (int i = 0; i < 20; i++) begin
      sio_in = 1'($urandom);
      wait_clk(HALF); sck = 1'b1;
      wait_clk(HALF); sck = 1'b0;
    end
    wait_clk(2);
    rst = 1'b1;
    wait_clk(1);
    chk("midrst_sio_out",    {31'h0, sio_out},    32'h0);
    chk("midrst_sio_oe",     {31'h0, sio_oe},     32'h0);
    chk("midrst_shutdown",   {31'h0, shutdown},   32'h0);
    chk("midrst_frame_done", {31'h0, frame_done}, 32'h0);
    chk("midrst_cmd_valid",  {31'h0, cmd_valid},  32'h0);
    rst = 1'b0;
    model_shdn = 1'b0;
    wait_clk(6);
    cs_n = 1'b1;
    wait_clk(12);
    chk("midrst_oe_after_cs", {31'h0, sio_oe}, 32'h0);

    // SCK activity with CS high
    for (int i = 0; i < 5; i++) begin
      sck = 1'b1; wait_clk(HALF);
      chk("oe_cs_high", {31'h0, sio_oe}, 32'h0);
      sck = 1'b0; wait_clk(HALF);
      chk("oe_cs_high", {31'h0, sio_oe}, 32'h0);
    end

    // randomized frames
    for (int k = 0; k < 25; k++) begin
      int          sel;
      int          nck;
      logic [15:0] wr;
      temp_in = 11'($urandom);
      sel = $urandom_range(0, 4);
      case (sel)
        0: nck = 7;
        1: nck = 16;
        2: nck = 20;
        3: nck = 31;
        default: nck = 32;
      endcase
      wr = 16'($urandom);
      case ($urandom_range(0, 3))
        0: wr[7:0] = 8'hFF;
        1: wr[7:0] = 8'h00;
        2: wr[7:0] = 8'h55;
        default: ;
      endcase
      frame(nck, wr, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 15)) : -1,
            11'($urandom));
    end

    wait_clk(10);
    chk("rd_queue_drained",  exp_rd_q.size(),  0);
    chk("evt_queue_drained", exp_evt_q.size(), 0);
    chk("final_shutdown",    {31'h0, shutdown}, {31'h0, model_shdn});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
